// File: rtl/clap_judge.sv
// Rhythm-game judge: restarts the external clap counter, synchronises the raw clap
// level and scores each clap edge against a fixed beat schedule.
module clap_judge #(
    parameter logic [16:0] FIRST_BEAT  = 17'd1000,
    parameter logic [16:0] BEAT_PERIOD = 17'd2000,
    parameter logic [16:0] HIT_WINDOW  = 17'd100,
    parameter logic [7:0]  NUM_BEATS   = 8'd8,
    parameter logic [16:0] COUNT_MAX   = 17'd66080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clap_in,
    input  logic [16:0] count,
    output logic        go,
    output logic        done,
    output logic [7:0]  score,
    output logic [7:0]  misses,
    output logic [7:0]  beat_idx,
    output logic [1:0]  result,
    output logic        result_valid
);

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_HIT   = 2'b01;
    localparam logic [1:0] RES_EARLY = 2'b10;
    localparam logic [1:0] RES_MISS  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic        result_valid_q, result_valid_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  misses_q, misses_d;
    logic [7:0]  beat_idx_q, beat_idx_d;
    logic [1:0]  result_q, result_d;
    logic [16:0] target_q, target_d;
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

    logic        clap_edge;
    logic [17:0] count_x, lo, hi;
    logic        hit_ev, early_ev, late_ev, last_beat, at_max;

    // Window maths is done one bit wider so hi never wraps.
    assign clap_edge = s2_q & ~s3_q;
    assign count_x   = {1'b0, count};
    assign lo        = (target_q >= HIT_WINDOW) ? ({1'b0, target_q} - {1'b0, HIT_WINDOW}) : 18'd0;
    assign hi        = {1'b0, target_q} + {1'b0, HIT_WINDOW};
    assign hit_ev    = clap_edge && (count_x >= lo) && (count_x <= hi);
    assign early_ev  = clap_edge && (count_x < lo);
    assign late_ev   = count_x > hi;
    assign last_beat = beat_idx_q == (NUM_BEATS - 8'd1);
    assign at_max    = count == COUNT_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            go_q           <= 1'b0;
            result_valid_q <= 1'b0;
            score_q        <= 8'd0;
            misses_q       <= 8'd0;
            beat_idx_q     <= 8'd0;
            result_q       <= RES_NONE;
            target_q       <= FIRST_BEAT;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            go_q           <= go_d;
            result_valid_q <= result_valid_d;
            score_q        <= score_d;
            misses_q       <= misses_d;
            beat_idx_q     <= beat_idx_d;
            result_q       <= result_d;
            target_q       <= target_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (start)
                    state_d = S_RUN;
                else if ((hit_ev || late_ev) && last_beat)
                    state_d = S_DONE;
                else if (!hit_ev && !early_ev && !late_ev && at_max)
                    state_d = S_DONE;
            end
            S_DONE: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // go is suppressed right after a pulse so a held start never gives back-to-back pulses.
    always_comb begin
        go_d           = start & ~go_q;
        result_valid_d = 1'b0;
        score_d        = score_q;
        misses_d       = misses_q;
        beat_idx_d     = beat_idx_q;
        result_d       = result_q;
        target_d       = target_q;
        s1_d           = clap_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        if (start) begin
            score_d    = 8'd0;
            misses_d   = 8'd0;
            beat_idx_d = 8'd0;
            result_d   = RES_NONE;
            target_d   = FIRST_BEAT;
        end else if (state_q == S_RUN) begin
            if (hit_ev) begin
                result_d       = RES_HIT;
                result_valid_d = 1'b1;
                score_d        = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else if (early_ev) begin
                result_d       = RES_EARLY;
                result_valid_d = 1'b1;
                misses_d       = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
            end else if (late_ev) begin
                result_d       = RES_MISS;
                result_valid_d = 1'b1;
                misses_d       = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
            end
            if ((hit_ev || late_ev) && !last_beat) begin
                beat_idx_d = beat_idx_q + 8'd1;
                target_d   = target_q + BEAT_PERIOD;
            end
        end
    end

    assign go           = go_q;
    assign done         = (state_q == S_DONE);
    assign score        = score_q;
    assign misses       = misses_q;
    assign beat_idx     = beat_idx_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_clap_judge.sv
// Randomised and directed bench for clap_judge with a beat-schedule reference model
// and a scoreboard of expected judgements.
module tb_clap_judge;

    localparam int FIRST = 1000;
    localparam int PER   = 2000;
    localparam int HW    = 100;
    localparam int NB    = 8;
    localparam int CMAX  = 66080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clap_in = 1'b0;
    logic [16:0] count = 17'd0;
    logic        go, done, result_valid;
    logic [7:0]  score, misses, beat_idx;
    logic [1:0]  result;

    clap_judge dut (
        .clk(clk), .reset(reset), .start(start), .clap_in(clap_in), .count(count),
        .go(go), .done(done), .score(score), .misses(misses), .beat_idx(beat_idx),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [25:0] exp_q[$];   // {result, score, misses, beat_idx} per judgement
    logic [2:0]  ctl_q[$];   // {go, done, result_valid} per clock edge

    // Reference model state: rounds described by beat number, tallies and a 2-edge clap delay.
    int       m_state;       // 0 idle, 1 running, 2 finished
    int       m_beat, m_score, m_miss;
    logic [1:0] m_result;
    logic     m_go_prev, m_prev_clap;
    logic     pipe[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_beat = 0; m_score = 0; m_miss = 0; m_result = 2'b00;
        m_go_prev = 1'b0; m_prev_clap = 1'b0;
        pipe.delete(); pipe.push_back(1'b0); pipe.push_back(1'b0);
    endtask

    task automatic model_step(input logic st, input logic cl, input int cnt);
        logic judged, exp_go, rv, adv;
        int tgt, lo, hi;
        judged = pipe.pop_front();
        pipe.push_back(cl && !m_prev_clap);
        m_prev_clap = cl;
        exp_go = st && !m_go_prev;
        m_go_prev = exp_go;
        rv = 1'b0;
        adv = 1'b0;
        if (st) begin
            m_state = 1; m_beat = 0; m_score = 0; m_miss = 0; m_result = 2'b00;
        end else if (m_state == 1) begin
            tgt = FIRST + m_beat * PER;
            lo  = (tgt >= HW) ? tgt - HW : 0;
            hi  = tgt + HW;
            if (judged && cnt >= lo && cnt <= hi) begin
                m_result = 2'b01; rv = 1'b1; adv = 1'b1;
                if (m_score < 255) m_score++;
            end else if (judged && cnt < lo) begin
                m_result = 2'b10; rv = 1'b1;
                if (m_miss < 255) m_miss++;
            end else if (cnt > hi) begin
                m_result = 2'b11; rv = 1'b1; adv = 1'b1;
                if (m_miss < 255) m_miss++;
            end else if (cnt == CMAX) begin
                m_state = 2;
            end
            if (adv) begin
                if (m_beat == NB - 1) m_state = 2;
                else m_beat++;
            end
            if (rv) exp_q.push_back({m_result, m_score[7:0], m_miss[7:0], m_beat[7:0]});
        end
        ctl_q.push_back({exp_go, (m_state == 2), rv});
    endtask

    task automatic cyc(input logic st, input logic cl, input int cnt);
        @(negedge clk);
        start = st; clap_in = cl; count = cnt[16:0];
        model_step(st, cl, cnt);
    endtask

    task automatic clap_at(input int cnt);
        repeat (3) cyc(1'b0, 1'b1, cnt);
        repeat (2) cyc(1'b0, 1'b0, cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; clap_in = 1'b0; count = 17'd0;
        @(posedge clk);
        #1;
        chk("rst_go", go, 0);
        chk("rst_done", done, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_beat", beat_idx, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares control outputs every edge and pops a judgement on each result_valid.
    initial begin
        logic [2:0]  ec;
        logic [25:0] er;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_q.size() != 0) begin
                ec = ctl_q.pop_front();
                chk("ctrl_go_done_rv", {go, done, result_valid}, ec);
            end
            if (result_valid) begin
                if (exp_q.size() == 0) chk("rv_unexpected", 1, 0);
                else begin
                    er = exp_q.pop_front();
                    chk("judgement", {result, score, misses, beat_idx}, er);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt, tgt;
        logic cl, st, near;
        model_reset();
        do_reset();

        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        clap_at(1050);
        chk("first_hit_score", score, 1);
        chk("first_hit_beat", beat_idx, 1);
        clap_at(2500);
        chk("early_beat_hold", beat_idx, 1);
        clap_at(3100);
        chk("edge_hit_score", score, 2);
        for (int c = 5095; c <= 5101; c++) cyc(1'b0, 1'b0, c);
        cyc(1'b0, 1'b1, 7099);
        cyc(1'b0, 1'b1, 7100);
        cyc(1'b0, 1'b1, 7101);
        cyc(1'b0, 1'b0, 7101);
        cyc(1'b0, 1'b0, 7101);
        chk("single_late_miss", misses, 3);
        chk("late_beat", beat_idx, 4);

        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        for (int b = 0; b < NB; b++) clap_at(FIRST + b * PER);
        chk("all_hit_done", done, 1);
        chk("all_hit_score", score, 8);
        chk("all_hit_beat", beat_idx, 7);
        clap_at(15000);
        clap_at(20000);

        repeat (3) cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        clap_at(1000);
        do_reset();

        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 1'b0, 0);
            cnt = 0;
            cl = 1'b0;
            for (int c = 0; c < 3600; c++) begin
                tgt  = FIRST + m_beat * PER;
                near = (cnt > tgt - 150) && (cnt < tgt + 150);
                if (near ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0)) cl = ~cl;
                st = ($urandom_range(0, 999) == 0);
                cyc(st, cl, cnt);
                if (st) cnt = 0;
                else cnt += $urandom_range(0, 40);
                if (cnt > CMAX) cnt = CMAX;
            end
        end

        repeat (4) cyc(1'b0, 1'b0, CMAX);
        @(posedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("ctl_q_drained", ctl_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clap_judge.md
Name: clap_judge

Overview:
- Rhythm-game scoring stage that sits around the clap-timing counter.
- Issues the one-cycle `go` that restarts the counter, then consumes the counter's 17-bit `count` value.
- Judges each player clap against a fixed beat schedule and drives score, miss and result outputs to the display logic.

Parameters:
FIRST_BEAT, 17'd1000, count value of beat 0
BEAT_PERIOD, 17'd2000, count spacing between consecutive beats
HIT_WINDOW, 17'd100, allowed +/- deviation for a hit (inclusive)
NUM_BEATS, 8'd8, beats per round (1..255)
COUNT_MAX, 17'd66080, terminal value of the counter; round ends if reached

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins or restarts a round
clap_in  input  1  raw active-high clap level (asynchronous, from key or mic comparator)
count  input  17  current value from the clap counter
go  output  1  one-cycle pulse to the counter: clear and begin counting
done  output  1  high while round complete
score  output  8  hits this round, saturates at 255
misses  output  8  early or missed beats this round, saturates at 255
beat_idx  output  8  index of the beat currently being judged
result  output  2  last judgement: 00 none, 01 hit, 10 early, 11 miss
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - State IDLE.
  - go, done, result_valid = 0.
  - score, misses, beat_idx = 0; result = 00; target = FIRST_BEAT.
  - Sync flops cleared.
- Clap input path:
  - clap_in passes through 2 sync flops (s1, s2), then s3; clap_edge = s2 & ~s3.
  - A clap_in rise before edge N gives clap_edge high in the cycle after edge N+1.
  - Judgement is registered at edge N+2 using the count value present at that edge.
  - One judgement per rising edge; held clap_in does not re-trigger.
- All window arithmetic is 18-bit unsigned.
  - lo = (target >= HIT_WINDOW) ? target - HIT_WINDOW : 0.
  - hi = target + HIT_WINDOW.
- State IDLE:
  - go = 0.
  - start -> go = 1 for exactly one cycle; score, misses, beat_idx, result cleared; target = FIRST_BEAT; -> RUN.
- State RUN (checks evaluated each cycle, in priority order):
  1. start: same action as from IDLE (restart mid-round; counts cleared; go re-pulsed).
  2. clap_edge and lo <= count <= hi:
     - result = 01; score += 1 (saturating).
     - Advance.
  3. clap_edge and count < lo:
     - result = 10; misses += 1.
     - No advance; same beat is still judgeable.
  4. count > hi, with or without clap_edge:
     - result = 11; misses += 1.
     - Advance. A late clap and timeout in the same cycle count as one miss, not two.
  5. count == COUNT_MAX with no other event: -> DONE; result unchanged.
  - result_valid pulses for exactly one cycle whenever result is written in items 2-4.
- Advance:
  - If beat_idx == NUM_BEATS-1 -> DONE; beat_idx holds.
  - Else beat_idx += 1, target += BEAT_PERIOD.
- State DONE:
  - done = 1; clap edges ignored; outputs hold.
  - start -> restart as in IDLE (done drops on the same edge go rises).
- Clap edge arriving in IDLE or DONE: ignored, no result_valid.
- go never asserts in two consecutive cycles, even if start is held high: start is treated as level-qualified and restarts once per IDLE/DONE exit; a held start in RUN restarts every cycle.

Test Plan:
- Reset then start -> go high exactly 1 cycle; score=0, misses=0, beat_idx=0, done=0, result=00.
- Drive count=1050, clap rising edge -> 2 cycles later result=01, result_valid 1 cycle, score=1, beat_idx=1, target now 3000.
- At beat_idx=1, clap with count=2500 -> result=10, misses=1, beat_idx stays 1. Then clap at count=3100 (boundary, inclusive) -> result=01, score=1->2.
- No clap and ramp count past 5100 at beat_idx=2 -> result=11 on the cycle count reaches 5101, misses+1, beat_idx=3. Also: clap_edge coincident with count=5101 gives a single miss, not two.
- Hit all 8 beats at their exact targets (1000, 3000, ... 15000) -> score=8, misses=0, done=1, beat_idx=7. Further claps -> no result_valid.
- Mid-round start at beat_idx=4 -> go pulse; score, misses, beat_idx cleared; target=1000. Also: reset asserted mid-RUN -> all outputs zero next cycle, state IDLE.
